// File: rtl/param_sequence_detector.sv
`default_nettype none
// ============================================================================
// Module   : param_sequence_detector
// Brief    : Runtime-programmable serial pattern detector with Moore/Mealy
//            output timing, overlap control and a saturating match counter.
// Revision : 1.0
// ============================================================================
module param_sequence_detector #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_WIDTH       = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
    parameter int                 DEFAULT_LEN     = 4,
    parameter int                 LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_serial,
    input  logic                 data_valid,
    input  logic                 cfg_load,
    input  logic [MAX_LEN-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    input  logic                 cfg_mealy,
    input  logic                 count_clear,
    output logic                 data_out,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 cfg_error
);

    localparam logic [LEN_W-1:0]     c_fill_max = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]     c_fill_one = LEN_W'(1);
    localparam logic [LEN_W:0]       c_ext_one  = (LEN_W + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic                 r_mealy;
    logic                 r_error;
    // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0]   r_history;
    logic [LEN_W-1:0]     r_fill;
    logic                 r_moore_out;
    logic [CNT_WIDTH-1:0] r_count;

    logic [MAX_LEN-1:0]   w_window;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_fill_ok;
    logic                 w_len_bad;
    logic                 w_match;

    assign w_window = {r_history, data_serial};

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_mask
        assign w_mask[g] = (r_len > LEN_W'(g));
    end

    assign w_fill_ok = (({1'b0, r_fill} + c_ext_one) >= {1'b0, r_len});
    assign w_len_bad = (cfg_len == '0) || (cfg_len > c_fill_max);

    // A bit arriving together with cfg_load is discarded, so it never matches.
    assign w_match = data_valid && !cfg_load && !r_error && w_fill_ok &&
                     (((w_window ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern   <= DEFAULT_PATTERN;
            r_len       <= LEN_W'(DEFAULT_LEN);
            r_overlap   <= 1'b1;
            r_mealy     <= 1'b0;
            r_error     <= 1'b0;
            r_history   <= '0;
            r_fill      <= '0;
            r_moore_out <= 1'b0;
            r_count     <= '0;
        end else begin
            if (count_clear) begin
                r_count <= '0;
            end else if (w_match && (r_count != c_cnt_max)) begin
                r_count <= r_count + c_cnt_one;
            end

            if (cfg_load) begin
                r_pattern   <= cfg_pattern;
                r_len       <= cfg_len;
                r_overlap   <= cfg_overlap;
                r_mealy     <= cfg_mealy;
                r_error     <= w_len_bad;
                r_history   <= '0;
                r_fill      <= '0;
                r_moore_out <= 1'b0;
            end else begin
                r_moore_out <= w_match;
                if (data_valid) begin
                    r_history <= w_window[MAX_LEN-2:0];
                    if (w_match && !r_overlap) begin
                        r_fill <= '0;
                    end else if (r_fill != c_fill_max) begin
                        r_fill <= r_fill + c_fill_one;
                    end
                end
            end
        end
    end

    assign data_out    = r_mealy ? w_match : r_moore_out;
    assign match_count = r_count;
    assign cfg_error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_param_sequence_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_sequence_detector
// Brief    : Self-checking bench for param_sequence_detector (two counter widths).
// Revision : 1.0
// ============================================================================
module tb_param_sequence_detector;

    localparam int ML    = 8;
    localparam int LW    = $clog2(ML + 1);
    localparam int CW_A  = 16;
    localparam int CW_B  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_serial;
    logic          data_valid;
    logic          cfg_load;
    logic [ML-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          cfg_overlap;
    logic          cfg_mealy;
    logic          count_clear;

    logic            data_out_a, data_out_b;
    logic [CW_A-1:0] count_a;
    logic [CW_B-1:0] count_b;
    logic            err_a, err_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    param_sequence_detector #(.MAX_LEN(ML), .CNT_WIDTH(CW_A)) dut_a (
        .clk(clk), .reset(reset), .data_serial(data_serial), .data_valid(data_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_mealy(cfg_mealy), .count_clear(count_clear),
        .data_out(data_out_a), .match_count(count_a), .cfg_error(err_a)
    );

    param_sequence_detector #(.MAX_LEN(ML), .CNT_WIDTH(CW_B)) dut_b (
        .clk(clk), .reset(reset), .data_serial(data_serial), .data_valid(data_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_mealy(cfg_mealy), .count_clear(count_clear),
        .data_out(data_out_b), .match_count(count_b), .cfg_error(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: list of bits since last restart ----------
    bit          m_q[$];
    bit [ML-1:0] m_pat;
    int          m_len;
    bit          m_ovl, m_mealy, m_err, m_moore, m_init;
    int          m_cnt_a, m_cnt_b;

    function automatic bit model_match();
        bit b;
        if (!data_valid || cfg_load || m_err) return 1'b0;
        if (m_q.size() + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == 0) ? data_serial : m_q[m_q.size() - k];
            if (b != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit mt;
        if (reset) begin
            m_q.delete();
            m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1; m_mealy = 0;
            m_err = 0; m_moore = 0; m_cnt_a = 0; m_cnt_b = 0; m_init = 1;
        end else if (m_init) begin
            mt = model_match();
            if (count_clear) begin
                m_cnt_a = 0; m_cnt_b = 0;
            end else if (mt) begin
                if (m_cnt_a < (1 << CW_A) - 1) m_cnt_a++;
                if (m_cnt_b < (1 << CW_B) - 1) m_cnt_b++;
            end
            if (cfg_load) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                m_mealy = cfg_mealy; m_err = (m_len == 0) || (m_len > ML);
                m_q.delete(); m_moore = 0;
            end else begin
                m_moore = mt;
                if (data_valid) begin
                    m_q.push_back(data_serial);
                    if (m_q.size() > ML) void'(m_q.pop_front());
                    if (mt && !m_ovl) m_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        bit exp_out;
        if (m_init) begin
            exp_out = m_mealy ? model_match() : m_moore;
            check("data_out_a", 32'(data_out_a), 32'(exp_out));
            check("data_out_b", 32'(data_out_b), 32'(exp_out));
            check("count_a", 32'(count_a), 32'(m_cnt_a));
            check("count_b", 32'(count_b), 32'(m_cnt_b));
            check("cfg_error", 32'(err_a), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic d, input logic ld, input logic clr);
        data_valid = v; data_serial = d; cfg_load = ld; count_clear = clr;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bit_in(input logic d);
        drive(1'b1, d, 1'b0, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bits_in(input logic [ML-1:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(pat[i]);
    endtask

    task automatic load(input logic [ML-1:0] p, input int l, input logic o, input logic m);
        cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o; cfg_mealy = m;
        drive(1'b0, 1'b0, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_count();
        drive(1'b0, 1'b0, 1'b0, 1'b1); tick(); drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cfg_pattern = 8'b0000_1011; cfg_len = LW'(4); cfg_overlap = 1'b1; cfg_mealy = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("reset data_out", 32'(data_out_a), 32'd0);
        check("reset count", 32'(count_a), 32'd0);
        check("reset cfg_error", 32'(err_a), 32'd0);

        // Default Moore overlap: 1,0,1,1,0,1,1
        bits_in(8'b0000_1011, 4);
        check("moore first pulse", 32'(data_out_a), 32'd1);
        bit_in(1'b0);
        check("moore pulse one cycle", 32'(data_out_a), 32'd0);
        bits_in(8'b0000_0011, 2);
        check("moore overlap pulse", 32'(data_out_a), 32'd1);
        check("moore count", 32'(count_a), 32'd2);

        // Mealy, no overlap
        load(8'b0000_1011, 4, 1'b0, 1'b1);
        bits_in(8'b0000_0101, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b0); #1;
        check("mealy same cycle", 32'(data_out_a), 32'd1);
        tick();
        bits_in(8'b0000_0001, 2);
        drive(1'b1, 1'b1, 1'b0, 1'b0); #1;
        check("mealy no overlap", 32'(data_out_a), 32'd0);
        tick(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("mealy count", 32'(count_a), 32'd3);

        // Idle gaps inside the pattern
        load(8'b0000_1011, 4, 1'b1, 1'b0);
        clear_count();
        check("count cleared", 32'(count_a), 32'd0);
        bits_in(8'b0000_0010, 2);
        tick(); tick(); tick();
        bits_in(8'b0000_0011, 2);
        check("gap match", 32'(data_out_a), 32'd1);
        check("gap count", 32'(count_a), 32'd1);

        // Illegal lengths
        load(8'b0000_1011, 0, 1'b1, 1'b0);
        check("len0 error", 32'(err_a), 32'd1);
        bits_in(8'b0000_1011, 4);
        check("len0 no match", 32'(count_a), 32'd1);
        load(8'b0000_1011, 9, 1'b1, 1'b0);
        check("len9 error", 32'(err_a), 32'd1);
        load(8'b0000_1011, 4, 1'b1, 1'b0);
        check("error cleared", 32'(err_a), 32'd0);
        bits_in(8'b0000_1011, 4);
        check("resume count", 32'(count_a), 32'd2);

        // Saturation of the 2-bit counter and clear priority
        clear_count();
        load(8'b0000_0011, 2, 1'b1, 1'b0);
        bits_in(8'b0011_1111, 6);
        check("sat count_b", 32'(count_b), 32'd3);
        check("count_a five", 32'(count_a), 32'd5);
        drive(1'b1, 1'b1, 1'b0, 1'b1); tick(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("clear wins a", 32'(count_a), 32'd0);
        check("clear wins b", 32'(count_b), 32'd0);
        check("clear pulse kept", 32'(data_out_a), 32'd1);

        // cfg_load coincident with the final bit
        load(8'b0000_1011, 4, 1'b1, 1'b0);
        bits_in(8'b0000_0101, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("load discards bit", 32'(data_out_a), 32'd0);
        check("load count", 32'(count_a), 32'd0);

        // Reset mid-stream restores defaults
        load(8'b0000_0110, 4, 1'b0, 1'b1);
        bits_in(8'b0000_0101, 3);
        reset = 1'b1; tick(); reset = 1'b0;
        bit_in(1'b1);
        check("reset loses partial", 32'(data_out_a), 32'd0);
        bits_in(8'b0000_0011, 3);
        check("defaults restored", 32'(data_out_a), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 5) begin
                reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                reset = 1'b0;
                if (r < 25) begin
                    cfg_pattern = ML'($urandom);
                    cfg_len = ($urandom_range(0, 1) == 0) ? LW'($urandom_range(1, 3))
                                                          : LW'($urandom_range(0, 9));
                    cfg_overlap = 1'($urandom);
                    cfg_mealy = 1'($urandom);
                end
                drive(($urandom_range(0, 3) != 0), 1'($urandom), (r < 25) && 1'($urandom),
                      ($urandom_range(0, 99) < 3));
            end
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_sequence_detector.md
Name: param_sequence_detector

Overview:
Runtime-programmable serial sequence detector that replaces the fixed Moore and Mealy detectors with one block. It consumes the par2ser serial stream qualified by data_valid. Pattern, length, overlap policy and Moore/Mealy output timing are all configurable. It keeps a saturating occurrence counter, so benches and software no longer count detector pulses externally.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
CNT_WIDTH, 16, width of match_count.
DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits, LSB-aligned).
DEFAULT_LEN, 4, pattern length loaded at reset.
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
data_serial  in  1  serial data bit
data_valid  in  1  data_serial is valid this cycle
cfg_load  in  1  one-cycle strobe, latch cfg_* fields
cfg_pattern  in  MAX_LEN  pattern, LSB-aligned; bit 0 = last bit received
cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_mealy  in  1  1 = Mealy output timing, 0 = Moore
count_clear  in  1  synchronous clear of match_count
data_out  out  1  detection pulse
match_count  out  CNT_WIDTH  saturating number of detections
cfg_error  out  1  active configuration is illegal; detection disabled

Behaviour:
- Reset:
  - active config = DEFAULT_PATTERN / DEFAULT_LEN, overlap=1, Moore.
  - history, fill=0; match_count=0; data_out=0; cfg_error=0.
- State:
  - history: MAX_LEN-bit shift register, newest bit in bit 0.
  - fill: 0..MAX_LEN counter of valid bits since last restart.
- Bit order: the first bit received maps to pattern[len-1]; the final bit maps to pattern[0].
- Shift: on each cycle with data_valid=1 and no cfg_load, history <= {history[MAX_LEN-2:0], data_serial}; fill increments, saturating at MAX_LEN.
- Match condition:
  - Evaluated combinationally on the incoming bit: data_valid=1, cfg_error=0, fill+1 >= len, and the low len bits of {history, data_serial} equal pattern[len-1:0].
  - Bits above len are ignored.
- On a match edge:
  - match_count increments, saturating at 2^CNT_WIDTH-1.
  - If overlap=0, fill <= 0, so the next match needs len fresh bits. If overlap=1, fill keeps counting.
- Mealy (cfg_mealy=1): data_out = match condition, combinational, asserted in the same cycle as the final bit.
- Moore (cfg_mealy=0):
  - data_out is registered and high for exactly one cycle, the cycle after the final bit, regardless of data_valid in that cycle.
  - Back-to-back matches give a continuously high data_out, one cycle per match.
- Counter timing: match_count updates on the same edge as the final bit in both modes.
- cfg_load:
  - Latches pattern, len, overlap and mealy; clears history, fill and the Moore output register.
  - A data bit presented in the same cycle is discarded and does not match.
  - The new config applies from the next cycle.
  - match_count is unchanged.
- cfg_error:
  - Set on the load edge if cfg_len==0 or cfg_len>MAX_LEN; while set, no matches occur.
  - Cleared by a legal cfg_load or by reset.
- count_clear: match_count <= 0 and takes priority over a simultaneous match increment. The data_out pulse still occurs.
- data_valid=0: history, fill and count hold; Mealy data_out=0.
- Reset mid-stream: partial matches are lost; config returns to the defaults.

Test Plan:
- Reset defaults (1011, len 4, overlap, Moore), stream 1,0,1,1,0,1,1 all valid -> data_out high in the cycles after bits 4 and 7; match_count=2.
- Load 1011, len 4, overlap=0, Mealy; same stream -> data_out high only during bit 4; match_count=1.
- Default config, stream 1,0,(valid=0 for 3 cycles),1,1 -> exactly one match; the idle gaps neither break nor create matches.
- cfg_len=0, then 9 (MAX_LEN=8) -> cfg_error=1, no matches on 1011; reload len 4 -> cfg_error=0 and detection resumes.
- CNT_WIDTH=2, overlap pattern 11 len 2, stream of six 1s -> match_count saturates at 3; count_clear in a match cycle -> 0, while the data_out pulse still appears.
- cfg_load while valid bit 4 of 1011 arrives -> no match; reset asserted after bits 1,0,1 then 1 -> no match, defaults restored.
